// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM duty sequencer.
//   state_t     : sequencer FSM states (idle, ramping up, ramping down)
//   STATE_W     : encoded state width
//   clamp_duty  : limits a requested duty to a ceiling (used on target commands)
package pwm_ctrl_pkg;

  localparam int STATE_W   = 2;
  localparam int DUTY_FN_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } state_t;

  // Generic-width clamp; callers size arguments to DUTY_FN_W and truncate the result.
  function automatic logic [DUTY_FN_W-1:0] clamp_duty(
    input logic [DUTY_FN_W-1:0] v,
    input logic [DUTY_FN_W-1:0] max_v
  );
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..PERIOD-1 and wraps.
//   i_clk        : system clock
//   i_rst        : synchronous active-high reset (counter to 0)
//   o_cnt        : current count
//   o_period_end : high while o_cnt == PERIOD-1 (the edge that ends the period)
module pwm_period_counter #(
  parameter int CNT_W  = 4,
  parameter int PERIOD = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_period_end
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_period_end = w_last;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// PWM duty controller. Owns the working duty (duty_sh), applies inc/dec pulses
// and ramped target commands to it, and copies it into the compare value
// (duty_act) only at period boundaries so the PWM output never glitches.
//   clk, rst     : clock, synchronous active-high reset
//   inc_pulse    : single-cycle request duty+1 (IDLE only, saturates at DUTY_MAX)
//   dec_pulse    : single-cycle request duty-1 (IDLE only, saturates at 0)
//   tgt_valid/tgt_duty/tgt_ready : target command; transfer happens on a clock
//                  edge where tgt_valid and tgt_ready are both high. tgt_ready is
//                  high only in IDLE and does not depend on tgt_valid.
//   busy         : a ramp is in progress
//   period_end   : high while the period counter is at PERIOD-1
//   duty_cur     : duty currently applied to the compare
//   pwm_out      : registered PWM output
//   o_dbg_state  : current FSM state, for observation only
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int PERIOD    = 10,
  parameter int DUTY_MAX  = 10,
  parameter int DUTY_INIT = 4,
  parameter int RAMP_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             tgt_valid,
  input  logic [CNT_W-1:0] tgt_duty,
  output logic             tgt_ready,
  output logic             busy,
  output logic             period_end,
  output logic [CNT_W-1:0] duty_cur,
  output logic             pwm_out,
  output state_t           o_dbg_state
);

  localparam int RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_duty_sh, w_duty_sh_nxt;
  logic [CNT_W-1:0]    r_duty_act;
  logic [CNT_W-1:0]    r_tgt, w_tgt_nxt;
  logic [RDIV_W-1:0]   r_rdiv, w_rdiv_nxt;
  logic                r_pwm;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_period_end;
  logic [CNT_W-1:0]    w_tgt_clamped;
  logic                w_rdiv_last;

  pwm_period_counter #(
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD)
  ) u_counter (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_cnt        (w_cnt),
    .o_period_end (w_period_end)
  );

  assign w_tgt_clamped = CNT_W'(clamp_duty(DUTY_FN_W'(tgt_duty), DUTY_FN_W'(DUTY_MAX)));
  assign w_rdiv_last   = (r_rdiv == RDIV_W'(RAMP_DIV - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_duty_sh_nxt = r_duty_sh;
    w_tgt_nxt     = r_tgt;
    w_rdiv_nxt    = r_rdiv;
    unique case (r_state)
      ST_IDLE: begin
        // An accepted target wins over any inc/dec pulse in the same cycle.
        if (tgt_valid) begin
          w_tgt_nxt  = w_tgt_clamped;
          w_rdiv_nxt = '0;
          if (w_tgt_clamped > r_duty_sh) begin
            w_state_nxt = ST_RAMP_UP;
          end else if (w_tgt_clamped < r_duty_sh) begin
            w_state_nxt = ST_RAMP_DOWN;
          end
        end else if (inc_pulse && !dec_pulse) begin
          if (r_duty_sh < CNT_W'(DUTY_MAX)) begin
            w_duty_sh_nxt = r_duty_sh + 1'b1;
          end
        end else if (dec_pulse && !inc_pulse) begin
          if (r_duty_sh != '0) begin
            w_duty_sh_nxt = r_duty_sh - 1'b1;
          end
        end
      end
      ST_RAMP_UP: begin
        if (w_period_end) begin
          if (w_rdiv_last) begin
            w_rdiv_nxt = '0;
            if (r_duty_sh < r_tgt) begin
              w_duty_sh_nxt = r_duty_sh + 1'b1;
            end
            if (w_duty_sh_nxt == r_tgt) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_rdiv_nxt = r_rdiv + 1'b1;
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (w_period_end) begin
          if (w_rdiv_last) begin
            w_rdiv_nxt = '0;
            if (r_duty_sh > r_tgt) begin
              w_duty_sh_nxt = r_duty_sh - 1'b1;
            end
            if (w_duty_sh_nxt == r_tgt) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_rdiv_nxt = r_rdiv + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_duty_sh  <= CNT_W'(DUTY_INIT);
      r_duty_act <= CNT_W'(DUTY_INIT);
      r_tgt      <= '0;
      r_rdiv     <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_duty_sh <= w_duty_sh_nxt;
      r_tgt     <= w_tgt_nxt;
      r_rdiv    <= w_rdiv_nxt;
      // Apply includes any update made to duty_sh in this same cycle.
      if (w_period_end) begin
        r_duty_act <= w_duty_sh_nxt;
      end
      r_pwm <= (w_cnt < r_duty_act);
    end
  end

  assign tgt_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
  assign period_end  = w_period_end;
  assign duty_cur    = r_duty_act;
  assign pwm_out     = r_pwm;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
module tb_pwm_duty_sequencer;
  import pwm_ctrl_pkg::*;

  localparam int CNT_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             inc_pulse = 1'b0;
  logic             dec_pulse = 1'b0;
  logic             tgt_valid = 1'b0;
  logic [CNT_W-1:0] tgt_duty  = '0;
  logic             tgt_ready;
  logic             busy;
  logic             period_end;
  logic [CNT_W-1:0] duty_cur;
  logic             pwm_out;
  state_t           dbg_state;

  int checks = 0;
  int errors = 0;

  pwm_duty_sequencer #(
    .CNT_W     (CNT_W),
    .PERIOD    (10),
    .DUTY_MAX  (10),
    .DUTY_INIT (4),
    .RAMP_DIV  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .tgt_valid   (tgt_valid),
    .tgt_duty    (tgt_duty),
    .tgt_ready   (tgt_ready),
    .busy        (busy),
    .period_end  (period_end),
    .duty_cur    (duty_cur),
    .pwm_out     (pwm_out),
    .o_dbg_state (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until the period_end edge has been taken; afterwards cnt is 0.
  task automatic apply_period(input string tag);
    int n;
    n = 0;
    while (period_end !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (period_end !== 1'b1) begin
      errors++;
      $display("FAIL %s period_end_timeout got=%b exp=1", tag, period_end);
    end
    tick();
  endtask

  // Starting at cnt=0, count pwm_out high cycles across one full period.
  task automatic count_highs(output int h);
    h = 0;
    repeat (10) begin
      tick();
      if (pwm_out === 1'b1) h++;
    end
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      inc_pulse = 1'b1;
      tick();
    end
    inc_pulse = 1'b0;
  endtask

  task automatic pulse_dec(input int n);
    repeat (n) begin
      dec_pulse = 1'b1;
      tick();
    end
    dec_pulse = 1'b0;
  endtask

  task automatic send_target(input logic [CNT_W-1:0] t);
    tgt_valid = 1'b1;
    tgt_duty  = t;
    tick();
    tgt_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    int h;
    rst = 1'b1;
    tick();
    checks++;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
    tick();
    rst = 1'b0;
    checks++;
    if (duty_cur !== 4'd4) begin errors++; $display("FAIL reset_duty got=%0d exp=4", duty_cur); end
    checks++;
    if (busy !== 1'b0 || tgt_ready !== 1'b1 || period_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b rdy=%b pe=%b exp=0/1/0", busy, tgt_ready, period_end);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    for (int p = 0; p < 3; p++) begin
      count_highs(h);
      checks++;
      if (h !== 4) begin errors++; $display("FAIL reset_highs period=%0d got=%0d exp=4", p, h); end
    end
  endtask

  task automatic test_inc_dec_saturate();
    int h;
    tick();                 // cnt=1
    pulse_inc(6);           // edges at cnt 1..6
    checks++;
    if (duty_cur !== 4'd4) begin errors++; $display("FAIL inc_before_apply got=%0d exp=4", duty_cur); end
    apply_period("inc");
    checks++;
    if (duty_cur !== 4'd10) begin errors++; $display("FAIL inc_sat got=%0d exp=10", duty_cur); end
    count_highs(h);
    checks++;
    if (h !== 10) begin errors++; $display("FAIL inc_highs got=%0d exp=10", h); end
    pulse_inc(1);           // beyond ceiling
    apply_period("inc_ceiling");
    checks++;
    if (duty_cur !== 4'd10) begin errors++; $display("FAIL inc_ceiling got=%0d exp=10", duty_cur); end
    pulse_dec(11);
    apply_period("dec");
    checks++;
    if (duty_cur !== 4'd0) begin errors++; $display("FAIL dec_sat got=%0d exp=0", duty_cur); end
    count_highs(h);
    checks++;
    if (h !== 0) begin errors++; $display("FAIL dec_highs got=%0d exp=0", h); end
  endtask

  task automatic test_inc_dec_same_cycle();
    int h;
    pulse_inc(4);
    apply_period("to4");
    checks++;
    if (duty_cur !== 4'd4) begin errors++; $display("FAIL setup4 got=%0d exp=4", duty_cur); end
    inc_pulse = 1'b1;
    dec_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    apply_period("both");
    checks++;
    if (duty_cur !== 4'd4) begin errors++; $display("FAIL both_pulses got=%0d exp=4", duty_cur); end
    count_highs(h);
    checks++;
    if (h !== 4) begin errors++; $display("FAIL both_highs got=%0d exp=4", h); end
  endtask

  task automatic test_ramp_up();
    send_target(4'd8);
    checks++;
    if (busy !== 1'b1 || tgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_start busy=%b rdy=%b exp=1/0", busy, tgt_ready);
    end
    pulse_inc(3);           // ignored while ramping
    send_target(4'd2);      // ignored while ramping
    for (int s = 5; s <= 8; s++) begin
      apply_period("ramp_a");
      checks++;
      if (duty_cur !== CNT_W'(s - 1) || busy !== 1'b1) begin
        errors++;
        $display("FAIL ramp_hold step=%0d duty=%0d busy=%b exp=%0d/1", s, duty_cur, busy, s - 1);
      end
      apply_period("ramp_b");
      checks++;
      if (duty_cur !== CNT_W'(s) || busy !== (s != 8)) begin
        errors++;
        $display("FAIL ramp_step step=%0d duty=%0d busy=%b exp=%0d/%b", s, duty_cur, busy, s, (s != 8));
      end
    end
  endtask

  task automatic test_targets();
    send_target(4'd15);
    repeat (4) apply_period("clamp");
    checks++;
    if (duty_cur !== 4'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tgt_clamp duty=%0d busy=%b exp=10/0", duty_cur, busy);
    end
    send_target(4'd15);     // clamps to 10 == current
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL tgt_equal busy=%b state=%0d exp=0/%0d", busy, dbg_state, ST_IDLE);
    end
    apply_period("eq");
    pulse_dec(7);
    apply_period("to3");
    checks++;
    if (duty_cur !== 4'd3) begin errors++; $display("FAIL setup3 got=%0d exp=3", duty_cur); end
    send_target(4'd1);
    checks++;
    if (dbg_state !== ST_RAMP_DOWN) begin errors++; $display("FAIL ramp_down_state got=%0d exp=%0d", dbg_state, ST_RAMP_DOWN); end
    apply_period("dn");
    apply_period("dn");
    checks++;
    if (duty_cur !== 4'd2 || busy !== 1'b1) begin errors++; $display("FAIL ramp_down_2 duty=%0d busy=%b exp=2/1", duty_cur, busy); end
    apply_period("dn");
    apply_period("dn");
    checks++;
    if (duty_cur !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL ramp_down_1 duty=%0d busy=%b exp=1/0", duty_cur, busy); end
    // accepted (equal) target with an inc pulse: pulse dropped
    tgt_valid = 1'b1;
    tgt_duty  = 4'd1;
    inc_pulse = 1'b1;
    tick();
    tgt_valid = 1'b0;
    inc_pulse = 1'b0;
    apply_period("prio");
    checks++;
    if (duty_cur !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL tgt_priority duty=%0d busy=%b exp=1/0", duty_cur, busy); end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    pulse_inc(3);
    apply_period("to4b");
    send_target(4'd9);
    repeat (4) apply_period("r6");
    checks++;
    if (duty_cur !== 4'd6 || busy !== 1'b1) begin errors++; $display("FAIL setup6 duty=%0d busy=%b exp=6/1", duty_cur, busy); end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || tgt_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ramp_state state=%0d rdy=%b busy=%b exp=%0d/1/0", dbg_state, tgt_ready, busy, ST_IDLE);
    end
    checks++;
    if (duty_cur !== 4'd4 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_ramp_duty duty=%0d pwm=%b exp=4/0", duty_cur, pwm_out);
    end
    n = 0;
    while (period_end !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 9) begin errors++; $display("FAIL rst_ramp_cnt cycles_to_end=%0d exp=9", n); end
    tick();
    checks++;
    if (duty_cur !== 4'd4) begin errors++; $display("FAIL rst_ramp_no_step got=%0d exp=4", duty_cur); end
  endtask

  initial begin
    test_reset();
    test_inc_dec_saturate();
    test_inc_dec_same_cycle();
    test_ramp_up();
    test_targets();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
